// File: rtl/clock_ctrl_if.sv
// Signal bundle between the time-of-day sequencer, its button/preset sources
// and the external seconds/minutes/hours counter chain.
interface clock_ctrl_if;
    logic [5:0] sec_q;
    logic [5:0] min_q;
    logic [4:0] hr_q;
    logic       btn_mode;
    logic       btn_inc;
    logic       preset;
    logic [5:0] preset_min;
    logic [4:0] preset_hr;
    logic       sec_ce;
    logic       sec_clr;
    logic       min_ce;
    logic       min_ld;
    logic       min_clr;
    logic [5:0] min_d;
    logic       hr_ce;
    logic       hr_ld;
    logic       hr_clr;
    logic [4:0] hr_d;
    logic       tick;
    logic [1:0] mode;

    // Handshake: no valid/ready; buttons and preset are single-cycle pulses
    // sampled every clock, and every control output acts on the next edge.
    modport master (
        input  sec_q, min_q, hr_q, btn_mode, btn_inc, preset, preset_min, preset_hr,
        output sec_ce, sec_clr, min_ce, min_ld, min_clr, min_d,
               hr_ce, hr_ld, hr_clr, hr_d, tick, mode
    );

    modport slave (
        output sec_q, min_q, hr_q, btn_mode, btn_inc, preset, preset_min, preset_hr,
        input  sec_ce, sec_clr, min_ce, min_ld, min_clr, min_d,
               hr_ce, hr_ld, hr_clr, hr_d, tick, mode
    );
endinterface

// File: rtl/clock_ctrl.sv
// Time-of-day sequencer: prescaled one-second tick, run/set modes and preset load
// driving the ce/ld/clr controls of external seconds, minutes and hours counters.
module clock_ctrl #(
    parameter int TICK_DIV = 4,
    parameter int DIVW     = 24
) (
    input  logic         clk,
    input  logic         rst,
    clock_ctrl_if.master io_bus
);
    typedef enum logic [1:0] {
        MODE_RUN     = 2'd0,
        MODE_SET_MIN = 2'd1,
        MODE_SET_HR  = 2'd2,
        MODE_BAD     = 2'd3
    } mode_e;

    localparam logic [DIVW-1:0] DIV_LAST = DIVW'(TICK_DIV - 1);

    mode_e           r_mode;
    mode_e           w_mode_nxt;
    logic [DIVW-1:0] r_div_cnt;
    logic            r_tick;
    logic            w_run_count;
    logic [5:0]      w_min_clamp;
    logic [4:0]      w_hr_clamp;

    always_comb begin
        w_mode_nxt = r_mode;
        case (r_mode)
            MODE_RUN:     if (io_bus.btn_mode) w_mode_nxt = MODE_SET_MIN;
            MODE_SET_MIN: if (io_bus.btn_mode) w_mode_nxt = MODE_SET_HR;
            MODE_SET_HR:  if (io_bus.btn_mode) w_mode_nxt = MODE_RUN;
            default:      w_mode_nxt = MODE_RUN;
        endcase
    end

    // Prescaler advances only while staying in RUN with no preset; anything else restarts it.
    assign w_run_count = (r_mode == MODE_RUN) && !io_bus.btn_mode && !io_bus.preset;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mode    <= MODE_RUN;
            r_div_cnt <= '0;
            r_tick    <= 1'b0;
        end else begin
            r_mode <= w_mode_nxt;
            if (w_run_count) begin
                r_div_cnt <= (r_div_cnt == DIV_LAST) ? '0 : r_div_cnt + 1'b1;
                r_tick    <= (r_div_cnt == DIV_LAST);
            end else begin
                r_div_cnt <= '0;
                r_tick    <= 1'b0;
            end
        end
    end

    assign w_min_clamp = (io_bus.preset_min > 6'd59) ? 6'd59 : io_bus.preset_min;
    assign w_hr_clamp  = (io_bus.preset_hr > 5'd23) ? 5'd23 : io_bus.preset_hr;

    always_comb begin
        io_bus.sec_ce  = 1'b0;
        io_bus.sec_clr = 1'b0;
        io_bus.min_ce  = 1'b0;
        io_bus.min_ld  = 1'b0;
        io_bus.min_clr = 1'b0;
        io_bus.min_d   = '0;
        io_bus.hr_ce   = 1'b0;
        io_bus.hr_ld   = 1'b0;
        io_bus.hr_clr  = 1'b0;
        io_bus.hr_d    = '0;
        if (!rst) begin
            io_bus.sec_clr = 1'b1;
            io_bus.min_clr = 1'b1;
            io_bus.hr_clr  = 1'b1;
        end else begin
            case (r_mode)
                MODE_RUN: begin
                    if (io_bus.preset && !io_bus.btn_mode) begin
                        io_bus.min_ce  = 1'b1;
                        io_bus.min_ld  = 1'b1;
                        io_bus.min_d   = w_min_clamp;
                        io_bus.hr_ce   = 1'b1;
                        io_bus.hr_ld   = 1'b1;
                        io_bus.hr_d    = w_hr_clamp;
                        io_bus.sec_clr = 1'b1;
                    end else if (r_tick) begin
                        io_bus.sec_ce = 1'b1;
                        if (io_bus.sec_q >= 6'd59) begin
                            io_bus.sec_clr = 1'b1;
                            io_bus.min_ce  = 1'b1;
                            if (io_bus.min_q >= 6'd59) begin
                                io_bus.min_clr = 1'b1;
                                io_bus.hr_ce   = 1'b1;
                                if (io_bus.hr_q >= 5'd23) io_bus.hr_clr = 1'b1;
                            end
                        end
                    end
                    // Entering SET_MIN zeroes seconds so the clock resumes on a whole minute.
                    if (io_bus.btn_mode) io_bus.sec_clr = 1'b1;
                end
                MODE_SET_MIN: begin
                    if (io_bus.btn_inc && !io_bus.btn_mode) begin
                        io_bus.min_ce = 1'b1;
                        if (io_bus.min_q >= 6'd59) io_bus.min_clr = 1'b1;
                    end
                end
                MODE_SET_HR: begin
                    if (io_bus.btn_inc && !io_bus.btn_mode) begin
                        io_bus.hr_ce = 1'b1;
                        if (io_bus.hr_q >= 5'd23) io_bus.hr_clr = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign io_bus.tick = r_tick;
    assign io_bus.mode = r_mode;
endmodule

// File: tb/tb_clock_ctrl.sv
// Directed bench for clock_ctrl: models the external counter chain and checks
// tick timing, carries, set modes, preset clamping, collisions and async reset.
module tb_clock_ctrl;
    localparam int TICK_DIV = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] sec_cnt;
    logic [5:0] min_cnt;
    logic [4:0] hr_cnt;
    int         n_checks = 0;
    int         n_fail   = 0;
    int         n;

    clock_ctrl_if bus();

    clock_ctrl #(.TICK_DIV(TICK_DIV), .DIVW(24)) dut (
        .clk    (clk),
        .rst    (rst),
        .io_bus (bus)
    );

    always #5 clk = ~clk;

    assign bus.sec_q = sec_cnt;
    assign bus.min_q = min_cnt;
    assign bus.hr_q  = hr_cnt;

    // External counters: clear beats enable, load only acts with enable.
    always @(posedge clk) begin
        if (bus.sec_clr)     sec_cnt <= '0;
        else if (bus.sec_ce) sec_cnt <= sec_cnt + 1'b1;
        if (bus.min_clr)     min_cnt <= '0;
        else if (bus.min_ce) min_cnt <= bus.min_ld ? bus.min_d : min_cnt + 1'b1;
        if (bus.hr_clr)      hr_cnt <= '0;
        else if (bus.hr_ce)  hr_cnt <= bus.hr_ld ? bus.hr_d : hr_cnt + 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] hms(input int h, input int m, input int s);
        return 32'(h * 10000 + m * 100 + s);
    endfunction

    function automatic logic [31:0] now_hms();
        return 32'(hr_cnt) * 10000 + 32'(min_cnt) * 100 + 32'(sec_cnt);
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_tick(output int cnt);
        cnt = 0;
        do begin
            cyc();
            cnt++;
        end while (bus.tick !== 1'b1 && cnt < 20);
        if (bus.tick !== 1'b1) check("tick_timeout", 32'(bus.tick), 32'd1);
    endtask

    task automatic press_mode();
        bus.btn_mode = 1'b1;
        cyc();
        bus.btn_mode = 1'b0;
    endtask

    task automatic press_inc();
        bus.btn_inc = 1'b1;
        cyc();
        bus.btn_inc = 1'b0;
    endtask

    task automatic do_preset(input logic [5:0] m, input logic [4:0] h);
        bus.preset_min = m;
        bus.preset_hr  = h;
        bus.preset     = 1'b1;
        cyc();
        bus.preset     = 1'b0;
    endtask

    initial begin
        rst            = 1'b0;
        bus.btn_mode   = 1'b0;
        bus.btn_inc    = 1'b0;
        bus.preset     = 1'b0;
        bus.preset_min = '0;
        bus.preset_hr  = '0;

        // Reset state
        #2;
        check("rst_mode", 32'(bus.mode), 32'd0);
        check("rst_tick", 32'(bus.tick), 32'd0);
        check("rst_clr", {29'd0, bus.sec_clr, bus.min_clr, bus.hr_clr}, 32'd7);
        check("rst_ce", {29'd0, bus.sec_ce, bus.min_ce, bus.hr_ce}, 32'd0);
        check("rst_ld", {30'd0, bus.min_ld, bus.hr_ld}, 32'd0);
        cyc();
        cyc();
        check("rst_time", now_hms(), hms(0, 0, 0));
        rst = 1'b1;

        // Run 60 ticks from 00:00:00
        for (int i = 1; i <= 60; i++) begin
            wait_tick(n);
            check("tick_period", 32'(n), 32'd4);
            check("sec_at_tick", 32'(sec_cnt), 32'(i - 1));
        end
        check("carry_sec_clr", 32'(bus.sec_clr), 32'd1);
        check("carry_min_ce", 32'(bus.min_ce), 32'd1);
        check("carry_min_clr", 32'(bus.min_clr), 32'd0);
        cyc();
        check("time_00_01_00", now_hms(), hms(0, 1, 0));

        // Full rollover from 23:59
        do_preset(6'd59, 5'd23);
        check("preset_23_59", now_hms(), hms(23, 59, 0));
        for (int i = 0; i < 59; i++) begin
            wait_tick(n);
            check("roll_period", 32'(n), 32'd4);
        end
        cyc();
        check("time_23_59_59", now_hms(), hms(23, 59, 59));
        wait_tick(n);
        check("roll_last_period", 32'(n), 32'd3);
        check("roll_clrs", {29'd0, bus.sec_clr, bus.min_clr, bus.hr_clr}, 32'd7);
        check("roll_ces", {29'd0, bus.sec_ce, bus.min_ce, bus.hr_ce}, 32'd7);
        cyc();
        check("time_rollover", now_hms(), hms(0, 0, 0));

        // Set modes
        bus.btn_inc = 1'b1;
        #1;
        check("inc_in_run_ignored", {30'd0, bus.min_ce, bus.hr_ce}, 32'd0);
        bus.btn_inc  = 1'b0;
        bus.btn_mode = 1'b1;
        #1;
        check("enter_set_sec_clr", 32'(bus.sec_clr), 32'd1);
        cyc();
        bus.btn_mode = 1'b0;
        check("mode_set_min", 32'(bus.mode), 32'd1);
        for (int i = 0; i < 3; i++) press_inc();
        check("min_plus_3", now_hms(), hms(0, 3, 0));
        for (int i = 0; i < 56; i++) press_inc();
        check("min_at_59", now_hms(), hms(0, 59, 0));
        bus.btn_inc = 1'b1;
        #1;
        check("set_min_wrap_clr", {30'd0, bus.min_clr, bus.hr_ce}, 32'd2);
        cyc();
        bus.btn_inc = 1'b0;
        check("set_min_wrap", now_hms(), hms(0, 0, 0));
        bus.preset_min = 6'd10;
        bus.preset_hr  = 5'd10;
        bus.preset     = 1'b1;
        #1;
        check("preset_in_set_ld", {30'd0, bus.min_ld, bus.hr_ld}, 32'd0);
        cyc();
        bus.preset = 1'b0;
        check("preset_in_set_time", now_hms(), hms(0, 0, 0));
        for (int i = 0; i < 6; i++) cyc();
        check("no_tick_in_set", 32'(bus.tick), 32'd0);
        bus.btn_mode = 1'b1;
        bus.btn_inc  = 1'b1;
        #1;
        check("mode_beats_inc_ce", 32'(bus.min_ce), 32'd0);
        cyc();
        bus.btn_mode = 1'b0;
        bus.btn_inc  = 1'b0;
        check("mode_set_hr", 32'(bus.mode), 32'd2);
        check("mode_beats_inc_time", now_hms(), hms(0, 0, 0));
        for (int i = 0; i < 23; i++) press_inc();
        check("hr_at_23", now_hms(), hms(23, 0, 0));
        bus.btn_inc = 1'b1;
        #1;
        check("set_hr_wrap_clr", 32'(bus.hr_clr), 32'd1);
        cyc();
        bus.btn_inc = 1'b0;
        check("set_hr_wrap", now_hms(), hms(0, 0, 0));
        press_mode();
        check("mode_run", 32'(bus.mode), 32'd0);
        wait_tick(n);
        check("first_tick_after_set", 32'(n), 32'd4);

        // Preset clamp
        cyc();
        bus.preset_min = 6'd63;
        bus.preset_hr  = 5'd31;
        bus.preset     = 1'b1;
        #1;
        check("clamp_min_d", 32'(bus.min_d), 32'd59);
        check("clamp_hr_d", 32'(bus.hr_d), 32'd23);
        check("clamp_ld_ce", {28'd0, bus.min_ce, bus.min_ld, bus.hr_ce, bus.hr_ld}, 32'd15);
        check("clamp_sec_clr", 32'(bus.sec_clr), 32'd1);
        cyc();
        bus.preset = 1'b0;
        check("clamp_time", now_hms(), hms(23, 59, 0));
        wait_tick(n);
        check("preset_restarts_div", 32'(n), 32'd4);

        // Preset colliding with a carry tick at 12:30:59
        do_preset(6'd30, 5'd12);
        check("preset_12_30", now_hms(), hms(12, 30, 0));
        for (int i = 0; i < 59; i++) wait_tick(n);
        wait_tick(n);
        check("collide_time_before", now_hms(), hms(12, 30, 59));
        bus.preset_min = 6'd30;
        bus.preset_hr  = 5'd12;
        bus.preset     = 1'b1;
        #1;
        check("collide_min_d", 32'(bus.min_d), 32'd30);
        check("collide_no_min_clr", 32'(bus.min_clr), 32'd0);
        cyc();
        bus.preset = 1'b0;
        check("collide_time_after", now_hms(), hms(12, 30, 0));

        // Async reset mid-count at 05:17:42
        do_preset(6'd17, 5'd5);
        for (int i = 0; i < 43; i++) wait_tick(n);
        check("pre_reset_time", now_hms(), hms(5, 17, 42));
        #2;
        rst = 1'b0;
        #1;
        check("async_tick", 32'(bus.tick), 32'd0);
        check("async_mode", 32'(bus.mode), 32'd0);
        check("async_clrs", {29'd0, bus.sec_clr, bus.min_clr, bus.hr_clr}, 32'd7);
        check("async_sec_ce", 32'(bus.sec_ce), 32'd0);
        cyc();
        check("async_time", now_hms(), hms(0, 0, 0));
        cyc();
        rst = 1'b1;
        wait_tick(n);
        check("tick_after_reset", 32'(n), 32'd4);
        press_mode();
        check("pre_reset_set_min", 32'(bus.mode), 32'd1);
        #3;
        rst = 1'b0;
        #1;
        check("async_mode_from_set", 32'(bus.mode), 32'd0);
        cyc();
        rst = 1'b1;
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
